// File: rtl/print_link_pkg.sv
// Shared framing definitions for the line-dump link.
// Used by both the transmit-side framer and the receive-side decoder.
package print_link_pkg;

  // Header length in bytes and the header itself; the first byte sent ('L')
  // sits in the most significant byte of the literal.
  localparam int              HDR_LEN     = 5;
  localparam logic [8*5-1:0]  LineHdr     = "LINE:";
  localparam logic [7:0]      LineTrailer = ":";

  // Reason reported alongside a discarded frame.
  typedef enum logic [1:0] {
    ERR_TRAILER = 2'd0,
    ERR_TIMEOUT = 2'd1
  } err_code_e;

  // Receive-side framing state.
  typedef enum logic [1:0] {
    HDR     = 2'd0,
    PAYLOAD = 2'd1,
    TRAILER = 2'd2
  } dec_state_e;

  // Header byte at position idx in transmit order (idx 0 is 'L').
  function automatic logic [7:0] hdr_byte(input logic [2:0] idx);
    return LineHdr[8*(HDR_LEN-1-int'(idx)) +: 8];
  endfunction

endpackage

// File: rtl/line_cmd_decoder.sv
// Receive-side parser for the line-dump link: recovers "LINE:" + payload + ":"
// frames from the UART byte stream, publishes complete lines and flags
// malformed or stalled frames.
module line_cmd_decoder
  import print_link_pkg::*;
#(
  parameter int HEAD_WIDTH   = 384,
  parameter int TIMEOUT_CLKS = 12_500
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  line_valid,
  output logic [HEAD_WIDTH-1:0] line_data,
  output logic                  frame_error,
  output logic [1:0]            error_code,
  output logic [15:0]           line_count
);

  localparam int PAYLOAD_BYTES = HEAD_WIDTH / 8;
  localparam int CNT_W         = $clog2(PAYLOAD_BYTES);
  localparam int TMO_W         = $clog2(TIMEOUT_CLKS);

  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(PAYLOAD_BYTES - 1);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CLKS - 1);
  localparam logic [2:0]       HDR_LAST  = 3'(HDR_LEN - 1);

  dec_state_e            r_state;
  logic [2:0]            r_hdr_idx;
  logic [CNT_W-1:0]      r_byte_cnt;
  logic [TMO_W-1:0]      r_idle;
  logic [HEAD_WIDTH-1:0] r_asm;
  logic [HEAD_WIDTH-1:0] r_line;
  logic [15:0]           r_count;
  logic                  r_line_valid;
  logic                  r_frame_error;
  err_code_e             r_error_code;

  logic w_mid_frame;
  logic w_expire;
  logic w_is_l;

  // Mid-frame means the idle timer is armed; a byte in the expiry cycle wins.
  assign w_mid_frame = (r_state != HDR) || (r_hdr_idx != 3'd0);
  assign w_expire    = w_mid_frame && !rx_valid && (r_idle == TMO_LAST);
  assign w_is_l      = (rx_data == hdr_byte(3'd0));

  // Framing FSM, idle timer, published line and all registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= HDR;
      r_hdr_idx     <= 3'd0;
      r_byte_cnt    <= '0;
      r_idle        <= '0;
      r_line        <= '0;
      r_count       <= 16'd0;
      r_line_valid  <= 1'b0;
      r_frame_error <= 1'b0;
      r_error_code  <= ERR_TRAILER;
    end else begin
      // NOTE: non-blocking assignments throughout, so every decision below
      // sees the pre-edge state regardless of statement order.
      r_line_valid  <= 1'b0;
      r_frame_error <= 1'b0;

      if (rx_valid || !w_mid_frame) begin
        r_idle <= '0;
      end else if (!w_expire) begin
        r_idle <= r_idle + TMO_W'(1);
      end

      if (w_expire) begin
        r_frame_error <= 1'b1;
        r_error_code  <= ERR_TIMEOUT;
        r_state       <= HDR;
        r_hdr_idx     <= 3'd0;
        r_idle        <= '0;
      end else if (rx_valid) begin
        unique case (r_state)
          HDR: begin
            if (rx_data == hdr_byte(r_hdr_idx)) begin
              if (r_hdr_idx == HDR_LAST) begin
                r_state    <= PAYLOAD;
                r_hdr_idx  <= 3'd0;
                r_byte_cnt <= '0;
              end else begin
                r_hdr_idx <= r_hdr_idx + 3'd1;
              end
            end else begin
              // A stray 'L' may itself start the real header.
              r_hdr_idx <= w_is_l ? 3'd1 : 3'd0;
            end
          end

          PAYLOAD: begin
            r_byte_cnt <= r_byte_cnt + CNT_W'(1);
            if (r_byte_cnt == LAST_BYTE) begin
              r_state <= TRAILER;
            end
          end

          TRAILER: begin
            r_state <= HDR;
            if (rx_data == LineTrailer) begin
              r_line       <= r_asm;
              r_count      <= r_count + 16'd1;
              r_line_valid <= 1'b1;
              r_hdr_idx    <= 3'd0;
            end else begin
              r_frame_error <= 1'b1;
              r_error_code  <= ERR_TRAILER;
              r_hdr_idx     <= w_is_l ? 3'd1 : 3'd0;
            end
          end

          default: begin
            r_state   <= HDR;
            r_hdr_idx <= 3'd0;
          end
        endcase
      end
    end
  end

  // Payload assembly register, written one byte per accepted payload strobe.
  // NOTE: deliberately not reset: a line is only published after all of its
  // bytes have been rewritten, so stale contents can never reach line_data.
  always_ff @(posedge clk) begin
    if (rx_valid && (r_state == PAYLOAD)) begin
      r_asm[8*r_byte_cnt +: 8] <= rx_data;
    end
  end

  assign line_valid  = r_line_valid;
  assign line_data   = r_line;
  assign frame_error = r_frame_error;
  assign error_code  = r_error_code;
  assign line_count  = r_count;

endmodule

// File: tb/tb_line_cmd_decoder.sv
// Self-checking bench for line_cmd_decoder: directed scenarios plus randomized
// frames, compared cycle by cycle against a frame-position reference model.
module tb_line_cmd_decoder;

  localparam int HW = 384;
  localparam int PB = HW / 8;
  localparam int T  = 12_500;
  localparam int FRAME_LEN = 5 + PB + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          line_valid;
  logic [HW-1:0] line_data;
  logic          frame_error;
  logic [1:0]    error_code;
  logic [15:0]   line_count;

  line_cmd_decoder #(.HEAD_WIDTH(HW), .TIMEOUT_CLKS(T)) dut (
    .clk         (clk),
    .reset       (reset),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .line_valid  (line_valid),
    .line_data   (line_data),
    .frame_error (frame_error),
    .error_code  (error_code),
    .line_count  (line_count)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_fail = 0;
  int n_checks = 0;

  // Observed pulse tallies, compared against bench-known expectations.
  int seen_lv = 0;
  int seen_fe = 0;

  // Reference model: pos is the count of frame bytes matched so far
  // (0..4 header, 5..5+PB-1 payload, 5+PB awaiting trailer).
  logic [7:0]    hdr_b [5];
  int            m_pos;
  int            m_idle;
  logic [HW-1:0] m_asm;
  logic [HW-1:0] m_line;
  logic [15:0]   m_count;
  logic          m_lv;
  logic          m_fe;
  logic [1:0]    m_ec;

  task automatic check(input string tag, input logic [HW-1:0] obs, input logic [HW-1:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pos = 0; m_idle = 0; m_line = '0; m_count = 16'd0;
    m_lv = 1'b0; m_fe = 1'b0; m_ec = 2'd0;
  endtask

  // Outputs expected after the coming clock edge given this cycle's inputs.
  task automatic model_cycle(input logic v, input logic [7:0] d);
    m_lv = 1'b0;
    m_fe = 1'b0;
    if (!v) begin
      if (m_pos != 0) begin
        if (m_idle == T - 1) begin
          m_fe = 1'b1; m_ec = 2'd1; m_pos = 0; m_idle = 0;
        end else begin
          m_idle++;
        end
      end
    end else begin
      m_idle = 0;
      if (m_pos < 5) begin
        if (d == hdr_b[m_pos]) m_pos++;
        else m_pos = (d == "L") ? 1 : 0;
      end else if (m_pos < 5 + PB) begin
        m_asm[8*(m_pos-5) +: 8] = d;
        m_pos++;
      end else begin
        if (d == ":") begin
          m_line = m_asm; m_count = m_count + 16'd1; m_lv = 1'b1; m_pos = 0;
        end else begin
          m_fe = 1'b1; m_ec = 2'd0; m_pos = (d == "L") ? 1 : 0;
        end
      end
    end
  endtask

  task automatic compare_all();
    if (line_valid === 1'b1) seen_lv++;
    if (frame_error === 1'b1) seen_fe++;
    check("line_valid", HW'(line_valid), HW'(m_lv));
    check("frame_error", HW'(frame_error), HW'(m_fe));
    check("line_data", line_data, m_line);
    check("line_count", HW'(line_count), HW'(m_count));
    if (m_fe) check("error_code", HW'(error_code), HW'(m_ec));
  endtask

  // One clock: drive at the falling edge, check at the next falling edge.
  task automatic tick(input logic v, input logic [7:0] d);
    rx_valid = v;
    rx_data  = v ? d : 8'h00;
    model_cycle(v, d);
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic send(input logic [7:0] d, input int max_gap);
    tick(1'b1, d);
    repeat ($urandom_range(0, max_gap)) tick(1'b0, 8'h00);
  endtask

  task automatic send_frame(input logic [HW-1:0] pl, input logic [7:0] trl, input int max_gap);
    for (int i = 0; i < 5; i++) send(hdr_b[i], max_gap);
    for (int k = 0; k < PB; k++) send(pl[8*k +: 8], max_gap);
    send(trl, max_gap);
  endtask

  task automatic do_reset();
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    reset    = 1'b1;
    #1;
    model_reset();
    check("rst_line_valid", HW'(line_valid), '0);
    check("rst_frame_error", HW'(frame_error), '0);
    check("rst_error_code", HW'(error_code), '0);
    check("rst_line_data", line_data, '0);
    check("rst_line_count", HW'(line_count), '0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  function automatic logic [HW-1:0] rand_payload();
    logic [HW-1:0] p;
    for (int k = 0; k < PB; k++) p[8*k +: 8] = 8'($urandom_range(0, 255));
    return p;
  endfunction

  initial begin
    logic [HW-1:0] pl;
    logic [HW-1:0] exp_v;
    int lv0, fe0;

    hdr_b[0] = "L"; hdr_b[1] = "I"; hdr_b[2] = "N"; hdr_b[3] = "E"; hdr_b[4] = ":";
    reset = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    @(negedge clk);
    do_reset();

    // 1: counting payload, back-to-back bytes.
    for (int k = 0; k < PB; k++) exp_v[8*k +: 8] = 8'(k);
    lv0 = seen_lv;
    send_frame(exp_v, ":", 0);
    check("t1_line_data", line_data, exp_v);
    check("t1_count", HW'(line_count), HW'(16'd1));
    tick(1'b0, 8'h00);
    check("t1_pulses", HW'(seen_lv - lv0), HW'(1));

    // 2: leading extra 'L' resynchronises onto the real header.
    for (int k = 0; k < PB; k++) exp_v[8*k +: 8] = 8'hA5;
    lv0 = seen_lv;
    send("L", 0);
    send_frame(exp_v, ":", 1);
    tick(1'b0, 8'h00);
    check("t2_line_data", line_data, exp_v);
    check("t2_pulses", HW'(seen_lv - lv0), HW'(1));

    // 3: good frame then bad trailer; line held, count unchanged by error.
    do_reset();
    pl = rand_payload();
    send_frame(pl, ":", 0);
    fe0 = seen_fe;
    send_frame(rand_payload(), "X", 0);
    check("t3_fe_pulses", HW'(seen_fe - fe0), HW'(1));
    check("t3_line_held", line_data, pl);
    check("t3_count", HW'(line_count), HW'(16'd1));

    // 4: stall after 10 payload bytes, then a clean frame.
    fe0 = seen_fe;
    for (int i = 0; i < 5; i++) send(hdr_b[i], 0);
    for (int k = 0; k < 10; k++) send(8'($urandom_range(0, 255)), 0);
    repeat (T + 3) tick(1'b0, 8'h00);
    check("t4_timeout_seen", HW'(seen_fe - fe0), HW'(1));
    pl = rand_payload();
    send_frame(pl, ":", 0);
    tick(1'b0, 8'h00);
    check("t4_after_line", line_data, pl);
    check("t4_count", HW'(line_count), HW'(16'd2));

    // 5: payload carrying header and trailer characters is opaque data.
    pl = rand_payload();
    pl[7:0] = ":";
    for (int i = 0; i < 5; i++) pl[8*(i+3) +: 8] = hdr_b[i];
    pl[8*(PB-1) +: 8] = ":";
    lv0 = seen_lv;
    send_frame(pl, ":", 0);
    tick(1'b0, 8'h00);
    check("t5_line_data", line_data, pl);
    check("t5_pulses", HW'(seen_lv - lv0), HW'(1));

    // 6: reset mid-frame drops it; next frame counts from 1.
    for (int i = 0; i < 5; i++) send(hdr_b[i], 0);
    for (int k = 0; k < 20; k++) send(8'($urandom_range(0, 255)), 0);
    do_reset();
    pl = rand_payload();
    send_frame(pl, ":", 1);
    tick(1'b0, 8'h00);
    check("t6_line_data", line_data, pl);
    check("t6_count", HW'(line_count), HW'(16'd1));

    // Randomized mix: good frames, bad trailers and inter-frame noise.
    for (int n = 0; n < 40; n++) begin
      int sel;
      sel = $urandom_range(0, 9);
      if (sel < 7) begin
        send_frame(rand_payload(), ":", $urandom_range(0, 2));
      end else if (sel < 9) begin
        send_frame(rand_payload(), ($urandom_range(0, 1) != 0) ? 8'h4C : 8'($urandom_range(0, 57)), 1);
      end else begin
        repeat ($urandom_range(1, 8)) send(($urandom_range(0, 2) == 0) ? 8'h4C : 8'($urandom_range(0, 255)), 2);
      end
    end
    repeat (4) tick(1'b0, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
